// File: rtl/capture_reader.sv
// Drains the circular logic-analyser capture RAM oldest-first after a capture completes,
// streaming each word with its frame index, trigger and last markers on a valid/ready port.
module capture_reader #(
    parameter int CHN_NUM = 8,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 1
) (
    input  logic                iSysClk,
    input  logic                iRst,
    input  logic                finished,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   pre_num,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [CHN_NUM-1:0]  rd_data,
    output logic [CHN_NUM-1:0]  o_data,
    output logic [ADDR_W-1:0]   o_idx,
    output logic                o_trig,
    output logic                o_last,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                busy,
    output logic                overrun
);

    localparam int FD    = RD_LAT + 1;
    localparam int PTR_W = $clog2(FD);
    localparam int CNT_W = $clog2(FD + 1);
    localparam int ENT_W = CHN_NUM + ADDR_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_nextState;

    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_pre;
    logic [ADDR_W:0]    r_rdCnt;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   r_fifoCount;
    logic [RD_LAT-1:0]  r_pipeVld;
    logic [RD_LAT-1:0]  r_pipeTrig;
    logic [RD_LAT-1:0]  r_pipeLast;
    logic [ADDR_W-1:0]  r_pipeIdx [RD_LAT];
    logic [ENT_W-1:0]   r_fifoMem [FD];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;

    logic               w_start;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_issueIdx;
    logic [CNT_W:0]     w_credit;

    function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FD - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_start    = finished && (r_state == S_IDLE);
    assign w_push     = r_pipeVld[RD_LAT-1];
    assign o_valid    = (r_fifoCount != '0);
    assign w_pop      = o_valid && i_ready;
    assign w_issueIdx = r_rdCnt[ADDR_W-1:0];
    assign busy       = (r_state != S_IDLE);
    assign rd_addr    = r_base + w_issueIdx;

    // A slot freed by this cycle's pop counts as credit, which keeps one read per cycle at full rate
    assign w_credit = {1'b0, r_fifoCount} + {1'b0, r_inflight} - {{CNT_W{1'b0}}, w_pop};
    assign rd_en    = (r_state == S_READ) && !r_rdCnt[ADDR_W] && (w_credit < (CNT_W+1)'(FD));

    assign {o_data, o_idx, o_trig, o_last} = r_fifoMem[r_rdPtr];

    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (finished)                           w_nextState = S_READ;
            S_READ:  if (rd_en && (w_issueIdx == '1))        w_nextState = S_DRAIN;
            S_DRAIN: if (w_pop && o_last)                    w_nextState = S_IDLE;
            default:                                         w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            r_base  <= '0;
            r_pre   <= '0;
            r_rdCnt <= '0;
            overrun <= 1'b0;
        end else if (w_start) begin
            r_base  <= start_addr;
            r_pre   <= pre_num;
            r_rdCnt <= '0;
            overrun <= 1'b0;
        end else begin
            if (finished) overrun <= 1'b1;
            if (rd_en)    r_rdCnt <= r_rdCnt + (ADDR_W+1)'(1);
        end
    end

    // Frame metadata travels alongside the RAM access so it lines up with rd_data on return
    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            r_pipeVld  <= '0;
            r_pipeTrig <= '0;
            r_pipeLast <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipeIdx[i] <= '0;
            r_inflight <= '0;
        end else begin
            r_pipeVld[0]  <= rd_en;
            r_pipeTrig[0] <= (w_issueIdx == r_pre);
            r_pipeLast[0] <= (w_issueIdx == '1);
            r_pipeIdx[0]  <= w_issueIdx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipeVld[i]  <= r_pipeVld[i-1];
                r_pipeTrig[i] <= r_pipeTrig[i-1];
                r_pipeLast[i] <= r_pipeLast[i-1];
                r_pipeIdx[i]  <= r_pipeIdx[i-1];
            end
            r_inflight <= r_inflight + CNT_W'(rd_en) - CNT_W'(w_push);
        end
    end

    always_ff @(posedge iSysClk) begin
        if (iRst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
            for (int i = 0; i < FD; i++) r_fifoMem[i] <= '0;
        end else begin
            if (w_push) begin
                r_fifoMem[r_wrPtr] <= {rd_data, r_pipeIdx[RD_LAT-1],
                                       r_pipeTrig[RD_LAT-1], r_pipeLast[RD_LAT-1]};
                r_wrPtr <= ptrNext(r_wrPtr);
            end
            if (w_pop) r_rdPtr <= ptrNext(r_rdPtr);
            case ({w_push, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + CNT_W'(1);
                2'b01:   r_fifoCount <= r_fifoCount - CNT_W'(1);
                default: r_fifoCount <= r_fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_reader.sv
// Directed bench for capture_reader: two instances (RD_LAT=1 and RD_LAT=3) share stimulus and
// a capture RAM model; every stream beat and read address is compared against bench-side values.
module tb_capture_reader;

    localparam int CHN_NUM = 8;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 1024;

    logic iSysClk = 1'b0;
    always #5 iSysClk = ~iSysClk;

    logic               iRst;
    logic               finished;
    logic               i_ready;
    logic [ADDR_W-1:0]  start_addr;
    logic [ADDR_W-1:0]  pre_num;

    logic               rdEnA, rdEnB;
    logic [ADDR_W-1:0]  rdAddrA, rdAddrB;
    logic [CHN_NUM-1:0] rdDataA, rdDataB;
    logic [CHN_NUM-1:0] oDataA, oDataB;
    logic [ADDR_W-1:0]  oIdxA, oIdxB;
    logic               oTrigA, oTrigB, oLastA, oLastB, oValidA, oValidB;
    logic               busyA, busyB, overrunA, overrunB;

    logic [7:0]         ram [DEPTH];
    logic [7:0]         ramB1, ramB2;

    // Capture RAM model: 1-cycle port for instance A, 3-cycle port for instance B
    always @(posedge iSysClk) rdDataA <= ram[rdAddrA];
    always @(posedge iSysClk) begin
        ramB1   <= ram[rdAddrB];
        ramB2   <= ramB1;
        rdDataB <= ramB2;
    end

    capture_reader #(.CHN_NUM(CHN_NUM), .ADDR_W(ADDR_W), .RD_LAT(1)) dutA (
        .iSysClk(iSysClk), .iRst(iRst), .finished(finished),
        .start_addr(start_addr), .pre_num(pre_num),
        .rd_en(rdEnA), .rd_addr(rdAddrA), .rd_data(rdDataA),
        .o_data(oDataA), .o_idx(oIdxA), .o_trig(oTrigA), .o_last(oLastA),
        .o_valid(oValidA), .i_ready(i_ready), .busy(busyA), .overrun(overrunA)
    );

    capture_reader #(.CHN_NUM(CHN_NUM), .ADDR_W(ADDR_W), .RD_LAT(3)) dutB (
        .iSysClk(iSysClk), .iRst(iRst), .finished(finished),
        .start_addr(start_addr), .pre_num(pre_num),
        .rd_en(rdEnB), .rd_addr(rdAddrB), .rd_data(rdDataB),
        .o_data(oDataB), .o_idx(oIdxB), .o_trig(oTrigB), .o_last(oLastB),
        .o_valid(oValidB), .i_ready(i_ready), .busy(busyB), .overrun(overrunB)
    );

    int          nChecks = 0;
    int          nErrors = 0;
    int          frameBase, framePre;
    int          expIdxA, expIdxB, rdIssuedA, rdIssuedB, trigA, trigB;
    logic        holdA, holdB;
    logic [19:0] heldA, heldB;
    bit          randReady;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] expTuple(input int idx);
        int a;
        a = (frameBase + idx) % DEPTH;
        return {ram[a], 10'(idx), (idx == framePre), (idx == DEPTH - 1)};
    endfunction

    // Per-cycle scoreboard, sampled at the falling edge while inputs are stable
    task automatic monitor();
        if (rdEnA) begin
            checkOutput("rdAddrA", 64'(rdAddrA), 64'((frameBase + rdIssuedA) % DEPTH));
            rdIssuedA++;
        end
        if (rdEnB) begin
            checkOutput("rdAddrB", 64'(rdAddrB), 64'((frameBase + rdIssuedB) % DEPTH));
            rdIssuedB++;
        end
        if (holdA) checkOutput("stallHoldA", {oValidA, oDataA, oIdxA, oTrigA, oLastA}, {1'b1, heldA});
        if (holdB) checkOutput("stallHoldB", {oValidB, oDataB, oIdxB, oTrigB, oLastB}, {1'b1, heldB});
        if (oValidA && i_ready) begin
            checkOutput("beatInFrameA", 64'(expIdxA < DEPTH), 64'(1));
            checkOutput("beatA", {oDataA, oIdxA, oTrigA, oLastA}, expTuple(expIdxA));
            if (oTrigA) trigA++;
            expIdxA++;
        end
        if (oValidB && i_ready) begin
            checkOutput("beatInFrameB", 64'(expIdxB < DEPTH), 64'(1));
            checkOutput("beatB", {oDataB, oIdxB, oTrigB, oLastB}, expTuple(expIdxB));
            if (oTrigB) trigB++;
            expIdxB++;
        end
        holdA = oValidA && !i_ready;
        holdB = oValidB && !i_ready;
        heldA = {oDataA, oIdxA, oTrigA, oLastA};
        heldB = {oDataB, oIdxB, oTrigB, oLastB};
        checkOutput("fifoBoundA", 64'(dutA.r_fifoCount <= 2), 64'(1));
        checkOutput("fifoBoundB", 64'(dutB.r_fifoCount <= 4), 64'(1));
    endtask

    task automatic tick();
        @(negedge iSysClk);
        monitor();
        @(posedge iSysClk);
        #1;
        if (randReady) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input int base, input int pre);
        start_addr = 10'(base);
        pre_num    = 10'(pre);
        finished   = 1'b1;
        frameBase  = base;
        framePre   = pre;
        expIdxA = 0; expIdxB = 0; rdIssuedA = 0; rdIssuedB = 0; trigA = 0; trigB = 0;
        tick();
        finished = 1'b0;
    endtask

    task automatic waitIdle();
        int g;
        g = 0;
        while ((busyA || busyB) && g < 5000) begin
            tick();
            g++;
        end
        checkOutput("idleTimeout", {busyA, busyB}, 2'b00);
    endtask

    task automatic checkFrameCounts(input string tag);
        checkOutput({tag, "_beatsA"}, 64'(expIdxA), 64'(DEPTH));
        checkOutput({tag, "_beatsB"}, 64'(expIdxB), 64'(DEPTH));
        checkOutput({tag, "_readsA"}, 64'(rdIssuedA), 64'(DEPTH));
        checkOutput({tag, "_readsB"}, 64'(rdIssuedB), 64'(DEPTH));
        checkOutput({tag, "_trigA"}, 64'(trigA), 64'(1));
        checkOutput({tag, "_trigB"}, 64'(trigB), 64'(1));
    endtask

    task automatic runFrame(input string tag, input int base, input int pre, input bit chkLat);
        int cyc, firstA, firstB, doneA, doneB;
        applyStimulus(base, pre);
        checkOutput({tag, "_accept"}, {busyA, busyB, overrunA, overrunB}, 4'b1100);
        firstA = -1; firstB = -1; doneA = -1; doneB = -1; cyc = 0;
        while (cyc < 5000) begin
            if (firstA < 0 && oValidA) firstA = cyc;
            if (firstB < 0 && oValidB) firstB = cyc;
            if (doneA < 0 && !busyA) doneA = cyc;
            if (doneB < 0 && !busyB) doneB = cyc;
            if (doneA >= 0 && doneB >= 0) break;
            tick();
            cyc++;
        end
        checkOutput({tag, "_done"}, {busyA, busyB}, 2'b00);
        if (chkLat) begin
            checkOutput({tag, "_firstValidA"}, 64'(firstA), 64'(2));
            checkOutput({tag, "_firstValidB"}, 64'(firstB), 64'(4));
            checkOutput({tag, "_frameCyclesA"}, 64'(doneA), 64'(DEPTH + 2));
            checkOutput({tag, "_frameCyclesB"}, 64'(doneB), 64'(DEPTH + 4));
        end
        checkFrameCounts(tag);
    endtask

    initial begin
        int g;
        iRst = 1'b1; finished = 1'b0; i_ready = 1'b1; start_addr = '0; pre_num = '0;
        randReady = 1'b0; holdA = 1'b0; holdB = 1'b0; heldA = '0; heldB = '0;
        frameBase = 0; framePre = 0;
        expIdxA = 0; expIdxB = 0; rdIssuedA = 0; rdIssuedB = 0; trigA = 0; trigB = 0;
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);

        repeat (3) tick();
        checkOutput("resetA", {rdEnA, rdAddrA, oDataA, oIdxA, oTrigA, oLastA, oValidA, busyA, overrunA}, '0);
        checkOutput("resetB", {rdEnB, rdAddrB, oDataB, oIdxB, oTrigB, oLastB, oValidB, busyB, overrunB}, '0);
        iRst = 1'b0;
        tick();

        $display("[TB] frame from address 0, trigger on beat 0");
        runFrame("linear", 0, 0, 1'b1);

        $display("[TB] wrapped frame from address 1000, trigger at index 24");
        runFrame("wrap", 1000, 24, 1'b1);

        $display("[TB] random backpressure, trigger on last beat");
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'((i * 37 + 11) & 255);
        randReady = 1'b1;
        runFrame("random", 300, 1023, 1'b0);
        randReady = 1'b0;
        i_ready = 1'b1;
        tick();

        $display("[TB] second finished mid-frame");
        applyStimulus(10, 500);
        repeat (50) tick();
        start_addr = 10'd777;
        pre_num    = 10'd3;
        finished   = 1'b1;
        tick();
        finished = 1'b0;
        checkOutput("overrunSet", {overrunA, overrunB, busyA, busyB}, 4'b1111);
        waitIdle();
        checkFrameCounts("overrunFrame");
        checkOutput("overrunSticky", {overrunA, overrunB}, 2'b11);
        runFrame("afterOverrun", 600, 0, 1'b1);

        $display("[TB] reset at beat 500");
        applyStimulus(0, 0);
        g = 0;
        while (expIdxA < 500 && g < 2000) begin
            tick();
            g++;
        end
        checkOutput("reachBeat500", 64'(expIdxA), 64'(500));
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        holdA = 1'b0;
        holdB = 1'b0;
        checkOutput("midReset", {oValidA, busyA, rdEnA, oValidB, busyB, rdEnB}, '0);
        repeat (5) tick();
        runFrame("postReset", 5, 100, 1'b1);

        $display("[TB] i_ready low for 100 cycles");
        i_ready = 1'b0;
        applyStimulus(200, 7);
        repeat (100) tick();
        checkOutput("stallReadsA", 64'(rdIssuedA), 64'(2));
        checkOutput("stallReadsB", 64'(rdIssuedB), 64'(4));
        checkOutput("stallState", {rdEnA, rdEnB, oValidA, oValidB}, 4'b0011);
        i_ready = 1'b1;
        waitIdle();
        checkFrameCounts("stallFrame");

        $display("[TB] finished coincident with reset");
        iRst = 1'b1;
        finished = 1'b1;
        start_addr = 10'd9;
        tick();
        iRst = 1'b0;
        finished = 1'b0;
        checkOutput("resetWins", {busyA, busyB, rdEnA, rdEnB}, 4'b0000);
        tick();
        checkOutput("resetWinsLater", {busyA, busyB, rdEnA, rdEnB, oValidA, oValidB}, '0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/capture_reader.md
Name: capture_reader

Overview:
Drains the 1024-deep logic-analyser capture RAM after the sample controller signals a completed capture. On the `finished` pulse it latches `start_addr` and reads the circular buffer oldest-first: `start_addr`, `start_addr+1`, … wrapping modulo depth, for exactly DEPTH words. Words go out on a valid/ready stream to the upload path (UART/USB framer or waveform display). Internal buffering absorbs RAM read latency and downstream backpressure.

Parameters:
CHN_NUM, 8, sample width in bits (one bit per channel)
ADDR_W, 10, capture RAM address width; DEPTH = 2**ADDR_W
RD_LAT, 1, RAM read latency in cycles from rd_en to valid rd_data; legal values 1..3

Ports:
iSysClk  in  1  system clock; all logic is on its rising edge
iRst  in  1  synchronous reset, active-high
finished  in  1  one-cycle capture-complete pulse from the sample controller
start_addr  in  ADDR_W  oldest-sample address; sampled only on an accepted finished
pre_num  in  ADDR_W  pre-trigger sample count; sampled with start_addr
rd_en  out  1  RAM read strobe
rd_addr  out  ADDR_W  RAM read address
rd_data  in  CHN_NUM  RAM read data; valid RD_LAT cycles after rd_en
o_data  out  CHN_NUM  stream sample
o_idx  out  ADDR_W  sample index 0..DEPTH-1 within the frame
o_trig  out  1  high on the beat where o_idx == latched pre_num
o_last  out  1  high on the beat where o_idx == DEPTH-1
o_valid  out  1  stream valid
i_ready  in  1  stream ready
busy  out  1  high from accepted start until the last beat is transferred
overrun  out  1  sticky; a finished arrived while busy

Behaviour:
- Reset: all outputs 0, FSM in IDLE, FIFO empty, in-flight count 0, overrun cleared. Reset mid-frame aborts the frame; in-flight RAM data is discarded.
- FSM states:
  - IDLE → READ on finished: latch base = start_addr and pre_num; zero rd_cnt and out_cnt; busy goes 1 on the next cycle.
  - READ → DRAIN when rd_cnt reaches DEPTH (all reads issued).
  - DRAIN → IDLE when the beat with o_last and i_ready is transferred. busy drops the same cycle the FSM enters IDLE.
- Read issue:
  - In READ, assert rd_en when fifo_count + inflight < RD_LAT+1.
  - rd_addr = base + rd_cnt, truncated to ADDR_W (wraps DEPTH-1 → 0). rd_cnt increments per issued read.
  - inflight increments on rd_en and decrements as data returns. A shift register of length RD_LAT tracks return timing.
- FIFO:
  - RD_LAT+1 entries, each holding {data, idx, trig, last}.
  - Push when the delayed valid returns. Pop when o_valid && i_ready. Simultaneous push and pop keeps the count unchanged.
  - The credit rule guarantees no overflow. An overflow is a design error; the bench asserts on it.
- Stream:
  - o_valid = FIFO non-empty; o_data/o_idx/o_trig/o_last come from the FIFO head.
  - Stream fields must hold stable while o_valid && !i_ready.
  - o_idx is assigned at issue time as rd_cnt, so o_idx 0 is the word at base.
- Throughput: with i_ready tied high, one beat per cycle after an initial RD_LAT+1 cycle latency from finished to the first o_valid. A full frame completes DEPTH+RD_LAT+1 cycles after finished.
- finished while busy (including the cycle busy deasserts): ignored, overrun set to 1. overrun clears on the next finished accepted in IDLE.
- finished in the same cycle as iRst: reset wins.
- pre_num ≥ DEPTH cannot occur (width-limited). Any value is legal; o_trig fires exactly once per frame.

Test Plan:
- Fill RAM[i]=i[7:0], start_addr=0, pre_num=0, i_ready=1, pulse finished → 1024 beats with o_data 0x00..0xFF repeating; o_trig on beat 0; o_last on idx 1023; first o_valid exactly 2 cycles after finished (RD_LAT=1).
- start_addr=1000, pre_num=24 → rd_addr sequence 1000..1023,0..999; o_idx 0 carries RAM[1000]; o_trig on o_idx 24 (RAM[0]); exactly 1024 rd_en pulses.
- Random i_ready (50% duty) → data stable while stalled, no beat lost or duplicated, FIFO never exceeds RD_LAT+1 entries; repeat with RD_LAT=3.
- Second finished mid-frame → frame completes unaltered; overrun=1. Next finished in IDLE → new frame starts and overrun=0.
- Assert iRst at beat 500 → o_valid=0, busy=0 next cycle. New finished (start_addr=5) → clean frame from RAM[5] with no stale data.
- i_ready=0 for 100 cycles after finished → exactly RD_LAT+1 reads issued, then rd_en stays low until i_ready rises.
